// File: rtl/efect_sequencer.sv
// -----------------------------------------------------------------------------
// efect_sequencer
//
// Command-driven sequencer for the POV LED effect decoder. ASCII command bytes
// from the UART receiver select the active effect; manual changes are held as
// pending and only applied on a revolution boundary (frame_tick) so a frame is
// never drawn half with one effect and half with another. Auto mode steps
// through every effect, dwelling dwell*DWELL_UNIT revolutions on each.
//
// Commands:
//   'E' d  : select effect '0'..'0'+NUM_EFECTS-1 (applied at next frame_tick)
//   'A' d  : auto mode, dwell d in '1'..'9'
//   'M'    : leave auto mode, keep current effect
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   rx_data     received UART byte
//   rx_valid    one-cycle strobe qualifying rx_data
//   frame_tick  one-cycle pulse at the start of each revolution
//   efect       active ASCII effect code ('0'..), to the one-hot decoder
//   auto_on     auto-cycle mode active
//   pending     manual effect change waiting for the next frame_tick
//   cmd_ok      one-cycle pulse: command accepted
//   cmd_err     one-cycle pulse: command rejected or timed out
// -----------------------------------------------------------------------------
module efect_sequencer #(
    parameter int unsigned NUM_EFECTS = 6,
    parameter int unsigned DWELL_UNIT = 8,
    parameter int unsigned TIMEOUT    = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       frame_tick,
    output logic [6:0] efect,
    output logic       auto_on,
    output logic       pending,
    output logic       cmd_ok,
    output logic       cmd_err
);

    // -------------------------------------------------------------------------
    // Constants
    // -------------------------------------------------------------------------
    localparam logic [6:0] CODE_FIRST = 7'd48;
    localparam logic [6:0] CODE_LAST  = 7'(48 + NUM_EFECTS - 1);

    localparam int unsigned   TMO_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // Large enough for the longest dwell: 9 * DWELL_UNIT - 1.
    localparam int unsigned FC_W = $clog2(9 * DWELL_UNIT + 1);

    localparam logic [7:0] CHAR_E = 8'h45;
    localparam logic [7:0] CHAR_A = 8'h41;
    localparam logic [7:0] CHAR_M = 8'h4D;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StGotE = 2'd1;
    localparam logic [1:0] StGotA = 2'd2;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [1:0]       state_q,   state_d;
    logic [TMO_W-1:0] tmo_q,     tmo_d;
    logic [6:0]       efect_q,   efect_d;
    logic [6:0]       pcode_q,   pcode_d;
    logic             pending_q, pending_d;
    logic             auto_q,    auto_d;
    logic [3:0]       dwell_q,   dwell_d;
    logic [FC_W-1:0]  fc_q,      fc_d;
    logic             ok_q,      ok_d;
    logic             err_q,     err_d;

    // -------------------------------------------------------------------------
    // Byte classification
    // -------------------------------------------------------------------------
    logic is_cmd_e;
    logic is_cmd_a;
    logic is_cmd_m;
    logic is_dig_e;
    logic is_dig_a;

    always_comb begin
        // Exact 8-bit compares also reject anything with bit 7 set.
        is_cmd_e = (rx_data == CHAR_E);
        is_cmd_a = (rx_data == CHAR_A);
        is_cmd_m = (rx_data == CHAR_M);
        is_dig_e = ({1'b0, rx_data} >= 9'd48) &&
                   ({1'b0, rx_data} <  9'(48 + NUM_EFECTS));
        is_dig_a = (rx_data >= 8'h31) && (rx_data <= 8'h39);
    end

    // -------------------------------------------------------------------------
    // Command parser FSM
    // -------------------------------------------------------------------------
    logic e_take;   // 'E' command completes this edge
    logic a_take;   // 'A' command completes this edge
    logic m_take;   // 'M' command completes this edge

    always_comb begin
        state_d = state_q;
        tmo_d   = tmo_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        e_take  = 1'b0;
        a_take  = 1'b0;
        m_take  = 1'b0;

        unique case (state_q)
            StIdle: begin
                tmo_d = '0;
                if (rx_valid) begin
                    if (is_cmd_e) begin
                        state_d = StGotE;
                    end else if (is_cmd_a) begin
                        state_d = StGotA;
                    end else if (is_cmd_m) begin
                        ok_d   = 1'b1;
                        m_take = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            StGotE, StGotA: begin
                // A received byte always wins over an expiring timeout.
                if (rx_valid) begin
                    state_d = StIdle;
                    tmo_d   = '0;
                    if (state_q == StGotE && is_dig_e) begin
                        ok_d   = 1'b1;
                        e_take = 1'b1;
                    end else if (state_q == StGotA && is_dig_a) begin
                        ok_d   = 1'b1;
                        a_take = 1'b1;
                    end else begin
                        // New command letters are discarded too, not restarted.
                        err_d = 1'b1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = StIdle;
                    tmo_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            default: begin
                state_d = StIdle;
                tmo_d   = '0;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Effect selection: frame application and auto advance
    // -------------------------------------------------------------------------
    logic [FC_W-1:0] fc_term;
    logic [6:0]      efect_next;

    always_comb begin
        fc_term    = FC_W'(dwell_q * DWELL_UNIT - 1);
        efect_next = (efect_q >= CODE_LAST) ? CODE_FIRST : efect_q + 7'd1;
    end

    always_comb begin
        efect_d   = efect_q;
        pcode_d   = pcode_q;
        pending_d = pending_q;
        auto_d    = auto_q;
        dwell_d   = dwell_q;
        fc_d      = fc_q;

        // The tick acts on the state held before this edge; a command that
        // completes on the same edge is layered on top below.
        if (frame_tick) begin
            if (pending_q) begin
                efect_d   = pcode_q;
                pending_d = 1'b0;
            end
            // An 'E' or 'A' completing now suppresses the advance.
            if (auto_q && !e_take && !a_take) begin
                if (fc_q == fc_term) begin
                    fc_d    = '0;
                    efect_d = efect_next;
                end else begin
                    fc_d = fc_q + 1'b1;
                end
            end
        end

        if (e_take) begin
            pcode_d   = rx_data[6:0];
            pending_d = 1'b1;
            auto_d    = 1'b0;
        end

        if (a_take) begin
            dwell_d   = rx_data[3:0];
            auto_d    = 1'b1;
            fc_d      = '0;
            pending_d = 1'b0;
        end

        if (m_take) begin
            auto_d = 1'b0;
        end
    end

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            tmo_q     <= '0;
            efect_q   <= CODE_FIRST;
            pcode_q   <= CODE_FIRST;
            pending_q <= 1'b0;
            auto_q    <= 1'b0;
            dwell_q   <= 4'd1;
            fc_q      <= '0;
            ok_q      <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tmo_q     <= tmo_d;
            efect_q   <= efect_d;
            pcode_q   <= pcode_d;
            pending_q <= pending_d;
            auto_q    <= auto_d;
            dwell_q   <= dwell_d;
            fc_q      <= fc_d;
            ok_q      <= ok_d;
            err_q     <= err_d;
        end
    end

    // -------------------------------------------------------------------------
    // Outputs
    // -------------------------------------------------------------------------
    assign efect   = efect_q;
    assign auto_on = auto_q;
    assign pending = pending_q;
    assign cmd_ok  = ok_q;
    assign cmd_err = err_q;

endmodule

// File: tb/tb_efect_sequencer.sv
// -----------------------------------------------------------------------------
// tb_efect_sequencer
//
// Directed bench for efect_sequencer (NUM_EFECTS=6, DWELL_UNIT=8, TIMEOUT=16).
// Expected command responses are queued as each byte is driven and popped
// when the response cycle is sampled; effect values come from a small model.
// -----------------------------------------------------------------------------
module tb_efect_sequencer;

    localparam int unsigned NUM_EFECTS = 6;
    localparam int unsigned DWELL_UNIT = 8;
    localparam int unsigned TIMEOUT    = 16;

    logic       clk;
    logic       rst_n;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_tick;
    logic [6:0] efect;
    logic       auto_on;
    logic       pending;
    logic       cmd_ok;
    logic       cmd_err;

    efect_sequencer #(
        .NUM_EFECTS (NUM_EFECTS),
        .DWELL_UNIT (DWELL_UNIT),
        .TIMEOUT    (TIMEOUT)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .frame_tick (frame_tick),
        .efect      (efect),
        .auto_on    (auto_on),
        .pending    (pending),
        .cmd_ok     (cmd_ok),
        .cmd_err    (cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic ok;
        logic err;
    } resp_t;

    resp_t exp_q[$];

    int n_checks = 0;
    int n_pass   = 0;

    // Model state for effect tracking.
    int         model_fc    = 0;
    int         model_dwell = 1;
    logic [6:0] exp_e       = 7'd48;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Drive one byte (optionally with a coincident frame_tick) and check the
    // cmd_ok/cmd_err response against the queued expectation.
    task automatic send(input logic [7:0] b, input logic ok, input logic err,
                        input logic with_tick);
        resp_t r;
        r.ok  = ok;
        r.err = err;
        exp_q.push_back(r);
        @(negedge clk);
        rx_data    = b;
        rx_valid   = 1'b1;
        frame_tick = with_tick;
        @(posedge clk);
        #1;
        rx_valid   = 1'b0;
        frame_tick = 1'b0;
        r = exp_q.pop_front();
        check("cmd_ok", {31'd0, cmd_ok}, {31'd0, r.ok});
        check("cmd_err", {31'd0, cmd_err}, {31'd0, r.err});
    endtask

    task automatic tick();
        @(negedge clk);
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One revolution in auto mode, checked against the dwell model.
    task automatic auto_tick();
        tick();
        if (model_fc == model_dwell * int'(DWELL_UNIT) - 1) begin
            model_fc = 0;
            exp_e    = (exp_e == 7'd53) ? 7'd48 : exp_e + 7'd1;
        end else begin
            model_fc++;
        end
        check("efect_auto", {25'd0, efect}, {25'd0, exp_e});
        check("auto_on_auto", {31'd0, auto_on}, 32'd1);
        idle(1);
    endtask

    initial begin
        resp_t r;
        rst_n      = 1'b0;
        rx_data    = 8'h00;
        rx_valid   = 1'b0;
        frame_tick = 1'b0;

        // Reset values
        idle(2);
        check("rst_efect", {25'd0, efect}, 32'd48);
        check("rst_auto", {31'd0, auto_on}, 32'd0);
        check("rst_pending", {31'd0, pending}, 32'd0);
        check("rst_ok", {31'd0, cmd_ok}, 32'd0);
        check("rst_err", {31'd0, cmd_err}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1);

        // 'E','3' then a tick 20 cycles later
        send(8'h45, 1'b0, 1'b0, 1'b0);
        send(8'h33, 1'b1, 1'b0, 1'b0);
        check("e3_pending", {31'd0, pending}, 32'd1);
        check("e3_efect_hold", {25'd0, efect}, 32'd48);
        idle(1);
        check("e3_ok_one_cycle", {31'd0, cmd_ok}, 32'd0);
        idle(19);
        check("e3_efect_pre_tick", {25'd0, efect}, 32'd48);
        tick();
        exp_e = 7'd51;
        check("e3_efect_post_tick", {25'd0, efect}, {25'd0, exp_e});
        check("e3_pending_clear", {31'd0, pending}, 32'd0);

        // Rejections: bad digit, unknown letter, lowercase, bit 7 set
        send(8'h45, 1'b0, 1'b0, 1'b0);
        send(8'h37, 1'b0, 1'b1, 1'b0);
        check("e7_pending", {31'd0, pending}, 32'd0);
        check("e7_efect", {25'd0, efect}, {25'd0, exp_e});
        send(8'h58, 1'b0, 1'b1, 1'b0);
        send(8'h65, 1'b0, 1'b1, 1'b0);
        send(8'hC5, 1'b0, 1'b1, 1'b0);
        // A new command letter in GOT_E is discarded, not restarted
        send(8'h45, 1'b0, 1'b0, 1'b0);
        send(8'h41, 1'b0, 1'b1, 1'b0);
        send(8'h31, 1'b0, 1'b1, 1'b0);
        check("rej_auto", {31'd0, auto_on}, 32'd0);

        // Auto mode, dwell 2: 96 revolutions
        send(8'h41, 1'b0, 1'b0, 1'b0);
        send(8'h32, 1'b1, 1'b0, 1'b0);
        check("a2_auto", {31'd0, auto_on}, 32'd1);
        model_fc    = 0;
        model_dwell = 2;
        for (int i = 0; i < 96; i++) auto_tick();

        // 'M' leaves auto mode, effect kept
        send(8'h4D, 1'b1, 1'b0, 1'b0);
        check("m_auto", {31'd0, auto_on}, 32'd0);
        tick();
        check("m_efect", {25'd0, efect}, {25'd0, exp_e});

        // Timeout after 'E': silent for 15 cycles, error on the 16th
        send(8'h45, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < int'(TIMEOUT); k++) begin
            idle(1);
            check("tmo_quiet", {31'd0, cmd_err}, 32'd0);
        end
        r.ok  = 1'b0;
        r.err = 1'b1;
        exp_q.push_back(r);
        idle(1);
        r = exp_q.pop_front();
        check("tmo_err", {31'd0, cmd_err}, {31'd0, r.err});
        check("tmo_ok", {31'd0, cmd_ok}, {31'd0, r.ok});
        send(8'h32, 1'b0, 1'b1, 1'b0);
        check("tmo_pending", {31'd0, pending}, 32'd0);

        // 'E','1' completing on a frame_tick edge
        send(8'h45, 1'b0, 1'b0, 1'b0);
        send(8'h31, 1'b1, 1'b0, 1'b1);
        check("e1_tick_efect", {25'd0, efect}, {25'd0, exp_e});
        check("e1_tick_pending", {31'd0, pending}, 32'd1);
        tick();
        exp_e = 7'd49;
        check("e1_next_efect", {25'd0, efect}, {25'd0, exp_e});
        check("e1_next_pending", {31'd0, pending}, 32'd0);

        // 'A','1' completing on a tick: counter cleared, no advance
        send(8'h41, 1'b0, 1'b0, 1'b0);
        send(8'h31, 1'b1, 1'b0, 1'b1);
        check("a1_tick_efect", {25'd0, efect}, {25'd0, exp_e});
        model_fc    = 0;
        model_dwell = 1;
        for (int i = 0; i < 7; i++) auto_tick();

        // 'E','5' on the tick that would otherwise advance
        send(8'h45, 1'b0, 1'b0, 1'b0);
        send(8'h35, 1'b1, 1'b0, 1'b1);
        check("e5_efect", {25'd0, efect}, {25'd0, exp_e});
        check("e5_auto", {31'd0, auto_on}, 32'd0);
        check("e5_pending", {31'd0, pending}, 32'd1);

        // Reset mid-revolution with a pending change
        idle(2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst2_efect", {25'd0, efect}, 32'd48);
        check("rst2_auto", {31'd0, auto_on}, 32'd0);
        check("rst2_pending", {31'd0, pending}, 32'd0);
        idle(1);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rst2_post_efect", {25'd0, efect}, 32'd48);
        check("rst2_post_pending", {31'd0, pending}, 32'd0);
        check("scoreboard_empty", exp_q.size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
